// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Parametrised up/down counter with a programmable modulus,
//   synchronous clear and load (load values past the range are clamped),
//   wrap flagging, and a combinational terminal_count for cascading stages.
//
//   Configuration macro COUNTER_SATURATE_EN:
//     undefined (default) - modulo counting; wrap_pulse marks each wrap.
//     defined             - the count saturates at the bound in the current
//                           direction; wrap_pulse is tied low.
//
//   Next-state arithmetic is carried in WIDTH+1 bits, so MODULUS == 2**WIDTH
//   needs no special handling: the carry or borrow of the extended sum is the
//   bound detect.
module param_updown_counter #(
  parameter int WIDTH       = 8,
  parameter int MODULUS     = 2**WIDTH,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal_count,
  output logic             wrap_pulse
);

  // Modulus and last legal value, widened to the internal arithmetic width.
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST      = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             at_top;
  logic             at_bottom;
  logic             load_over;

  // Bound detection from the extended increment/decrement results.
  always_comb begin
    inc_ext   = {1'b0, cnt_q} + 1'b1;
    dec_ext   = {1'b0, cnt_q} - 1'b1;
    // The next up-step reaching MODULUS means the count sits at MODULUS-1.
    at_top    = (inc_ext == MOD_EXT);
    // A borrow out of the decrement means the count sits at zero.
    at_bottom = dec_ext[WIDTH];
    load_over = ({1'b0, load_value} >= MOD_EXT);
  end

`ifdef COUNTER_SATURATE_EN

  // Next count: clear > load > enabled count (saturating) > hold.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else chain leaves it unassigned (which would infer a latch).
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_over ? LAST : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (!at_top) cnt_d = inc_ext[WIDTH-1:0];
      end else begin
        if (!at_bottom) cnt_d = dec_ext[WIDTH-1:0];
      end
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of evaluation order.
    if (!reset) cnt_q <= RESET_CNT;
    else        cnt_q <= cnt_d;
  end

  assign wrap_pulse = 1'b0;

`else

  logic wrap_q, wrap_d;

  // Next count and wrap flag: clear > load > enabled count (modulo) > hold.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else chain leaves it unassigned (which would infer a latch).
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_over ? LAST : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (at_top) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (at_bottom) begin
          cnt_d  = LAST;
          wrap_d = 1'b1;
        end else begin
          cnt_d = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // Count and wrap-pulse registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of evaluation order.
    if (!reset) begin
      cnt_q  <= RESET_CNT;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_pulse = wrap_q;

`endif

  assign counter_out = cnt_q;

  // High exactly when the next enabled edge reaches past the bound in the
  // current direction (wraps, or would wrap when saturating).
  assign terminal_count = enable & ((up_down & at_top) | (~up_down & at_bottom));

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter
//   Directed bench for param_updown_counter. Two instances share every input:
//   WIDTH=4/MODULUS=10 and WIDTH=4/MODULUS=16. A behavioural model computes the
//   expected state of each; expectations are queued when a step is driven and
//   popped and compared after the clock edge. The model follows
//   COUNTER_SATURATE_EN so the same bench covers either build.
module tb_param_updown_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [3:0] load_value;

  logic [3:0] cnt10, cnt16;
  logic       tc10, tc16;
  logic       wrap10, wrap16;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] c10;
    logic       w10;
    logic [3:0] c16;
    logic       w16;
  } exp_t;

  exp_t sb_q[$];

  int m10 = 0;
  int m16 = 0;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut10 (
    .clock          (clk),
    .reset          (reset),
    .enable         (enable),
    .up_down        (up_down),
    .clear          (clear),
    .load           (load),
    .load_value     (load_value),
    .counter_out    (cnt10),
    .terminal_count (tc10),
    .wrap_pulse     (wrap10)
  );

  param_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut16 (
    .clock          (clk),
    .reset          (reset),
    .enable         (enable),
    .up_down        (up_down),
    .clear          (clear),
    .load           (load),
    .load_value     (load_value),
    .counter_out    (cnt16),
    .terminal_count (tc16),
    .wrap_pulse     (wrap16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one counter for one clock edge.
  function automatic void model_next(input int modulus, input int cur, input bit en,
                                     input bit ud, input bit clr, input bit ld,
                                     input int lv, output int nxt, output bit wrap);
    nxt  = cur;
    wrap = 1'b0;
    if (clr) begin
      nxt = 0;
    end else if (ld) begin
      nxt = (lv > modulus - 1) ? modulus - 1 : lv;
    end else if (en) begin
`ifdef COUNTER_SATURATE_EN
      if (ud) nxt = (cur == modulus - 1) ? cur : cur + 1;
      else    nxt = (cur == 0) ? 0 : cur - 1;
`else
      if (ud) nxt = (cur + 1) % modulus;
      else    nxt = (cur + modulus - 1) % modulus;
      wrap = ud ? (cur == modulus - 1) : (cur == 0);
`endif
    end
  endfunction

  function automatic bit model_tc(input int modulus, input int cur, input bit en, input bit ud);
    return en && ((ud && cur == modulus - 1) || (!ud && cur == 0));
  endfunction

  // Drive one cycle of inputs at the falling edge, check terminal_count
  // combinationally, queue the expected post-edge state, then compare it.
  task automatic step(input string tag, input bit en, input bit ud, input bit clr,
                      input bit ld, input int lv);
    exp_t e;
    int   n10, n16;
    bit   w10, w16;
    @(negedge clk);
    enable     = en;
    up_down    = ud;
    clear      = clr;
    load       = ld;
    load_value = 4'(lv);
    #1;
    check({tag, "/tc10"}, 32'(tc10), 32'(model_tc(10, m10, en, ud)));
    check({tag, "/tc16"}, 32'(tc16), 32'(model_tc(16, m16, en, ud)));
    model_next(10, m10, en, ud, clr, ld, lv, n10, w10);
    model_next(16, m16, en, ud, clr, ld, lv, n16, w16);
    e.c10 = 4'(n10);
    e.w10 = w10;
    e.c16 = 4'(n16);
    e.w16 = w16;
    sb_q.push_back(e);
    m10 = n10;
    m16 = n16;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "/queue"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "/cnt10"},  32'(cnt10),  32'(e.c10));
      check({tag, "/wrap10"}, 32'(wrap10), 32'(e.w10));
      check({tag, "/cnt16"},  32'(cnt16),  32'(e.c16));
      check({tag, "/wrap16"}, 32'(wrap16), 32'(e.w16));
    end
  endtask

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    up_down    = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    load_value = '0;

    // Reset state, held over two edges.
    #1;
    check("rst/cnt10", 32'(cnt10), 32'd0);
    check("rst/wrap10", 32'(wrap10), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold/cnt10", 32'(cnt10), 32'd0);
    check("rst_hold/cnt16", 32'(cnt16), 32'd0);

    // Release with enable low: the next edge must not count.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("release/cnt10", 32'(cnt10), 32'd0);
    check("release/wrap10", 32'(wrap10), 32'd0);

    // Count up 12 clocks: 1..9,0,1,2 on the modulus-10 instance.
    for (int i = 0; i < 12; i++) step("up12", 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Load 3, then count down 5: 2,1,0,9,8.
    step("load3", 1'b0, 1'b0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 5; i++) step("down5", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Out-of-range load clamps; clear beats load and enable on the same edge.
    step("clamp", 1'b0, 1'b1, 1'b0, 1'b1, 15);
    step("clr_ld_en", 1'b1, 1'b1, 1'b1, 1'b1, 7);
    // Load wins over an enabled count at the bound.
    step("ld9", 1'b0, 1'b1, 1'b0, 1'b1, 9);
    step("ld_over_en", 1'b1, 1'b1, 1'b0, 1'b1, 2);

    // Reach 5 while counting, then assert reset between clock edges.
    step("ld4", 1'b0, 1'b1, 1'b0, 1'b1, 4);
    step("to5", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async/cnt10", 32'(cnt10), 32'd0);
    check("async/cnt16", 32'(cnt16), 32'd0);
    check("async/wrap10", 32'(wrap10), 32'd0);
    m10 = 0;
    m16 = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("async_hold/cnt10", 32'(cnt10), 32'd0);
      check("async_hold/cnt16", 32'(cnt16), 32'd0);
    end
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;

    // From 7 up 5 clocks; from 1 down 2 clocks (saturating build holds at bounds).
    step("ld7", 1'b0, 1'b1, 1'b0, 1'b1, 7);
    for (int i = 0; i < 5; i++) step("up_from7", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step("ld1", 1'b0, 1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 2; i++) step("down_from1", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Full-range instance: 15 -> 0 wrap, then flip direction at the bound every cycle.
    step("ld15", 1'b0, 1'b1, 1'b0, 1'b1, 15);
    step("wrap15", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) step("flip", 1'b1, i[0], 1'b0, 1'b0, 0);

    // Mixed traffic with occasional clear/load.
    for (int i = 0; i < 40; i++) begin
      step("mix", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)));
    end

    check("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
